// File: rtl/pattern_tx_pkg.sv
// Shared definitions for the pattern transmitter: state encoding and defaults.
package pattern_tx_pkg;

    localparam int          DEF_WIDTH   = 16;
    localparam int          DEF_LEN_W   = 5;
    localparam logic [15:0] DEF_PATTERN = 16'h5B72;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/pattern_tx_if.sv
// Request/serial-output bundle between a pattern source and the transmitter.
interface pattern_tx_if import pattern_tx_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] data;
    logic [LEN_W-1:0] len;
    logic [3:0]       rep;
    logic             out;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (output start, abort, data, len, rep,
                    input  out, valid, busy, done);
    modport slave  (input  start, abort, data, len, rep,
                    output out, valid, busy, done);
endinterface

// File: rtl/pattern_tx_ctr.sv
// Bit-index and pass counters; flags the last bit of a pass and the last pass.
module pattern_tx_ctr import pattern_tx_pkg::*; #(
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [LEN_W-1:0] eff_len,
    input  logic [3:0]       rep,
    output logic [LEN_W-1:0] idx,
    output logic             last_bit,
    output logic             last_pass
);
    logic [3:0] pass;

    assign last_bit  = (idx == eff_len - LEN_W'(1));
    assign last_pass = (pass == rep);

    // Step idx each shift cycle; wrap into the next pass without a gap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx  <= '0;
            pass <= '0;
        end else if (clear) begin
            idx  <= '0;
            pass <= '0;
        end else if (advance) begin
            if (last_bit) begin
                idx  <= '0;
                pass <= pass + 4'd1;
            end else begin
                idx  <= idx + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern LSB first, rep+1 times.
//   state | meaning
//   IDLE  | waiting for start, outputs quiet
//   SHIFT | driving one pattern bit per cycle
//   DONE  | one-cycle completion pulse
module pattern_tx import pattern_tx_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic         clock,
    input  logic         reset,
    pattern_tx_if.slave  bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic [LEN_W-1:0] len_q;
    logic [3:0]       rep_q;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] idx;
    logic             accept, advance, last_bit, last_pass;
    logic             valid, bit_sel;

    assign accept  = (state_q == IDLE) && bus.start && !bus.abort;
    // Zero or oversize lengths mean a full-width pass.
    assign len_eff = (bus.len == '0 || bus.len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : bus.len;

    // Capture the transfer parameters only when a start is accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            len_q  <= '0;
            rep_q  <= '0;
        end else if (accept) begin
            data_q <= bus.data;
            len_q  <= len_eff;
            rep_q  <= bus.rep;
        end
    end

    pattern_tx_ctr #(.LEN_W(LEN_W)) u_ctr (
        .clock     (clock),
        .reset     (reset),
        .clear     (accept),
        .advance   (advance),
        .eff_len   (len_q),
        .rep       (rep_q),
        .idx       (idx),
        .last_bit  (last_bit),
        .last_pass (last_pass)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and counter control; abort wins over everything.
    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        case (state_q)
            IDLE:  if (accept) state_d = SHIFT;
            SHIFT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (last_bit && last_pass) begin
                    state_d = DONE;
                end else begin
                    advance = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bit_sel   = |(data_q & (WIDTH'(1) << idx));
    assign valid     = (state_q == SHIFT);
    assign bus.valid = valid;
    assign bus.out   = valid & bit_sel;
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);

endmodule
